aes_stream_loader: RTL and testbench
====================================

Name: aes_stream_loader

Overview:
Word-stream front/back end for aes_cipher_top. Gathers 32-bit key and plaintext words from a valid/ready stream into 128-bit registers and issues the single-cycle ld pulse. Waits for done, captures text_out, and drains the ciphertext as four 32-bit words on an output valid/ready stream. Sits beside the cipher core in aes_top: it drives the core's ld/key/text_in and consumes its text_out/done.

Parameters:
DONE_TIMEOUT, 31, cycles allowed from ld to done before abort (5-bit counter, min 16)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_data  in  32  input word
in_key  in  1  1 = in_data is a key word, 0 = plaintext word
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
out_data  out  32  ciphertext word
out_valid  out  1  ciphertext word valid
out_ready  in  1  downstream accepts ciphertext word
aes_ld  out  1  load pulse to cipher core
aes_key  out  128  key to cipher core
aes_text_in  out  128  plaintext to cipher core
aes_text_out  in  128  ciphertext from cipher core
aes_done  in  1  cipher core done
busy  out  1  state != COLLECT
err  out  1  sticky error flag
err_clr  in  1  clears err, synchronous

Behaviour:
- Reset (rst low, async): state COLLECT; key_cnt=0, text_cnt=0, key_vld=0, tmo_cnt=0; aes_key, aes_text_in, result reg = 0; aes_ld, out_valid, err, busy = 0; in_ready forced 0 while rst low.
- Word order is big-endian: first word of a group -> bits [127:96], fourth -> [31:0]. The same order applies to output.
- COLLECT: in_ready = (text_cnt<4) | !key_vld.
  - Accepted key word: written to aes_key slot key_cnt; key_cnt wraps 3->0. Index 0 clears key_vld; index 3 sets key_vld.
  - Accepted text word with text_cnt<4: written to slot text_cnt; text_cnt++.
  - Accepted text word with text_cnt==4 (key not yet valid): word dropped, err set.
  - Key persists across blocks until a new index-0 key word arrives.
- COLLECT -> LOAD when text_cnt==4 & key_vld (registered; evaluated on post-update values). If the last word is accepted in cycle N, aes_ld=1 in cycle N+1.
- LOAD: one cycle, aes_ld=1, text_cnt<=0, tmo_cnt<=0 -> WAIT.
- WAIT: aes_key and aes_text_in held stable; tmo_cnt++.
  - aes_done=1: result <= aes_text_out -> DRAIN.
  - tmo_cnt==DONE_TIMEOUT without done: err set -> COLLECT, block discarded, key kept.
  - aes_done in the same cycle as timeout: done wins.
- DRAIN: out_valid=1, out_data = result word out_cnt.
  - out_valid & out_ready advances out_cnt; after word 3 -> COLLECT, out_valid drops the next cycle.
  - out_data is stable while out_valid & !out_ready.
- in_ready=0 in LOAD/WAIT/DRAIN; input words are not accepted there.
- aes_done outside WAIT is ignored.
- err: set by drop or timeout, cleared by err_clr; set wins over simultaneous clear.
- Reset mid-operation: immediate return to reset values; partial key, text and result are discarded.

Decomposition:
- aes_pkg: typedef enum logic [1:0] {COLLECT, LOAD, WAIT, DRAIN} ldr_state_t; localparam BLOCK_W=128, WORD_W=32, WORDS_PER_BLOCK=4.
- One sub-module, aes_word_pack: 4x32 indexed write register with 2-bit index. Instantiated for key and for text; the result reg is read by index mux in the top.

Test Plan:
- FIPS-197 vector: key words 00010203,04050607,08090a0b,0c0d0e0f, then text 00112233,44556677,8899aabb,ccddeeff with the real core -> ld one cycle after last word; out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; err=0.
- Key reuse: second block text ffeeddcc... with no new key words -> ld issued, output matches model ciphertext under the same key.
- Text before key: 4 text words, 5th text word, then 4 key words -> 5th dropped, err=1; ld fires after 4th key word with the original text; err_clr -> err=0.
- Timeout: stub core never asserts done -> err=1 at ld+1+DONE_TIMEOUT cycles, state COLLECT, in_ready=1, no out_valid.
- Output backpressure: out_ready low 10 cycles, then toggled every cycle -> out_data holds word, all 4 words delivered in order, in_ready=0 until the last is accepted.
- Reset during WAIT: rst low 2 cycles -> all outputs 0 immediately, key_vld=0; subsequent full key+text load produces correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES word-stream loader.
package aes_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } ldr_state_t;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    // Big-endian word select: index 0 is the most significant word.
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_stream_loader_if.sv
// Input word stream and output ciphertext stream of the loader.
// Handshake: a word moves on a cycle where valid & ready are both high; valid never waits on ready.
interface aes_stream_loader_if;
    import aes_pkg::*;

    logic [WORD_W-1:0] in_data;
    logic              in_key;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_key, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_key, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/aes_word_pack.sv
// 4x32 register written one word at a time; index 0 lands in bits [127:96].
module aes_word_pack
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [1:0]         idx,
    input  logic [WORD_W-1:0]  wdata,
    output logic [BLOCK_W-1:0] data
);

    logic [BLOCK_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (idx)
                2'd0:    data_d[127:96] = wdata;
                2'd1:    data_d[95:64]  = wdata;
                2'd2:    data_d[63:32]  = wdata;
                default: data_d[31:0]   = wdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_q <= '0;
        else      data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/aes_stream_loader.sv
// Gathers key/plaintext words for the AES core, pulses ld, waits for done
// and streams the 128-bit result back out as four words.
module aes_stream_loader
    import aes_pkg::*;
#(
    parameter int DONE_TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst,
    aes_stream_loader_if.slave  sif,
    output logic                aes_ld,
    output logic [BLOCK_W-1:0]  aes_key,
    output logic [BLOCK_W-1:0]  aes_text_in,
    input  logic [BLOCK_W-1:0]  aes_text_out,
    input  logic                aes_done,
    output logic                busy,
    output logic                err,
    input  logic                err_clr,
    output ldr_state_t          dbg_state,
    output logic                dbg_key_vld
);

    localparam logic [4:0] TMO_LIM = 5'(DONE_TIMEOUT);

    ldr_state_t         state_q, state_d;
    logic [1:0]         key_cnt_q, key_cnt_d;
    logic [2:0]         text_cnt_q, text_cnt_d;
    logic               key_vld_q, key_vld_d;
    logic [4:0]         tmo_cnt_q, tmo_cnt_d;
    logic [1:0]         out_cnt_q, out_cnt_d;
    logic [BLOCK_W-1:0] result_q, result_d;
    logic               err_q, err_d;

    logic in_ready_int, in_fire, key_wr, text_wr, err_set;

    assign in_ready_int = rst && (state_q == COLLECT) &&
                          ((text_cnt_q != 3'd4) || !key_vld_q);
    assign in_fire      = sif.in_valid && in_ready_int;
    assign key_wr       = in_fire && sif.in_key;
    assign text_wr      = in_fire && !sif.in_key && (text_cnt_q != 3'd4);

    always_comb begin
        state_d    = state_q;
        key_cnt_d  = key_cnt_q;
        text_cnt_d = text_cnt_q;
        key_vld_d  = key_vld_q;
        tmo_cnt_d  = tmo_cnt_q;
        out_cnt_d  = out_cnt_q;
        result_d   = result_q;
        err_d      = err_q;
        err_set    = 1'b0;

        case (state_q)
            COLLECT: begin
                if (key_wr) begin
                    key_cnt_d = key_cnt_q + 2'd1;
                    if (key_cnt_q == 2'd0) key_vld_d = 1'b0;
                    if (key_cnt_q == 2'd3) key_vld_d = 1'b1;
                end
                if (text_wr) text_cnt_d = text_cnt_q + 3'd1;
                // A full text block with no usable key has nowhere to put a fifth word.
                if (in_fire && !sif.in_key && (text_cnt_q == 3'd4)) err_set = 1'b1;
                if ((text_cnt_d == 3'd4) && key_vld_d) state_d = LOAD;
            end
            LOAD: begin
                text_cnt_d = 3'd0;
                tmo_cnt_d  = 5'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 5'd1;
                if (aes_done) begin
                    result_d  = aes_text_out;
                    out_cnt_d = 2'd0;
                    state_d   = DRAIN;
                end else if (tmo_cnt_d == TMO_LIM) begin
                    err_set = 1'b1;
                    state_d = COLLECT;
                end
            end
            DRAIN: begin
                if (sif.out_ready) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (err_clr) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            key_cnt_q  <= 2'd0;
            text_cnt_q <= 3'd0;
            key_vld_q  <= 1'b0;
            tmo_cnt_q  <= 5'd0;
            out_cnt_q  <= 2'd0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_cnt_q  <= key_cnt_d;
            text_cnt_q <= text_cnt_d;
            key_vld_q  <= key_vld_d;
            tmo_cnt_q  <= tmo_cnt_d;
            out_cnt_q  <= out_cnt_d;
            result_q   <= result_d;
            err_q      <= err_d;
        end
    end

    aes_word_pack u_key_pack (
        .clk   (clk),
        .rst   (rst),
        .wr_en (key_wr),
        .idx   (key_cnt_q),
        .wdata (sif.in_data),
        .data  (aes_key)
    );

    aes_word_pack u_text_pack (
        .clk   (clk),
        .rst   (rst),
        .wr_en (text_wr),
        .idx   (text_cnt_q[1:0]),
        .wdata (sif.in_data),
        .data  (aes_text_in)
    );

    assign sif.in_ready  = in_ready_int;
    assign sif.out_valid = (state_q == DRAIN);
    assign sif.out_data  = word_sel(result_q, out_cnt_q);
    assign aes_ld        = (state_q == LOAD);
    assign busy          = (state_q != COLLECT);
    assign err           = err_q;
    assign dbg_state     = state_q;
    assign dbg_key_vld   = key_vld_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Bench for aes_stream_loader: stub cipher core, word-level reference model,
// directed scenarios followed by randomized blocks.
module tb_aes_stream_loader;
    import aes_pkg::*;

    localparam int DONE_TIMEOUT = 31;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_stream_loader_if sif ();

    logic         aes_ld, aes_done, busy, err, err_clr, dbg_key_vld;
    logic [127:0] aes_key, aes_text_in, aes_text_out;
    ldr_state_t   dbg_state;

    aes_stream_loader #(.DONE_TIMEOUT(DONE_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .sif          (sif),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_text_out (aes_text_out),
        .aes_done     (aes_done),
        .busy         (busy),
        .err          (err),
        .err_clr      (err_clr),
        .dbg_state    (dbg_state),
        .dbg_key_vld  (dbg_key_vld)
    );

    // Stand-in cipher: known FIPS-197 answer, otherwise a cheap keyed mix.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return {t[63:0], t[127:64]} ^ k ^ {4{32'h5a3c96e1}};
    endfunction

    logic         stub_en, stub_done, extra_done;
    int           done_lat, stub_cnt;
    logic [127:0] stub_ct_q;

    assign aes_done     = stub_done | extra_done;
    assign aes_text_out = stub_done ? stub_ct_q : ~stub_ct_q;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            stub_ct_q <= '0;
        end else begin
            stub_done <= 1'b0;
            if (aes_ld && stub_en) begin
                stub_cnt  <= done_lat;
                stub_ct_q <= core_fn(aes_key, aes_text_in);
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) stub_done <= 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: words as the spec describes them, no counters of the DUT.
    logic [31:0] m_key [4];
    int          m_kidx;
    bit          m_kvld;
    logic [31:0] m_txt [$];
    logic [31:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_key[i] = '0;
        m_kidx = 0;
        m_kvld = 1'b0;
        m_txt.delete();
        exp_q.delete();
    endtask

    task automatic send_word(input logic [31:0] w, input bit is_key);
        int k = 0;
        bit exp_rdy;
        logic [127:0] kblk, tblk, ct;
        exp_rdy = (m_txt.size() < 4) || !m_kvld;
        sif.in_data  = w;
        sif.in_key   = is_key;
        sif.in_valid = 1'b1;
        chk("in_ready", sif.in_ready, exp_rdy);
        while (!sif.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!sif.in_ready) begin
            chk("in_ready_wait", sif.in_ready, 1);
            sif.in_valid = 1'b0;
            return;
        end
        tick();
        sif.in_valid = 1'b0;
        if (is_key) begin
            m_key[m_kidx] = w;
            if (m_kidx == 0) m_kvld = 1'b0;
            if (m_kidx == 3) m_kvld = 1'b1;
            m_kidx = (m_kidx + 1) % 4;
        end else if (m_txt.size() < 4) begin
            m_txt.push_back(w);
        end
        if (m_txt.size() == 4 && m_kvld) begin
            kblk = {m_key[0], m_key[1], m_key[2], m_key[3]};
            tblk = {m_txt[0], m_txt[1], m_txt[2], m_txt[3]};
            chk("ld_pulse", aes_ld, 1);
            chk("ld_key", aes_key, kblk);
            chk("ld_text", aes_text_in, tblk);
            ct = core_fn(kblk, tblk);
            exp_q.push_back(ct[127:96]);
            exp_q.push_back(ct[95:64]);
            exp_q.push_back(ct[63:32]);
            exp_q.push_back(ct[31:0]);
            m_txt.delete();
        end else begin
            chk("no_ld", aes_ld, 0);
        end
    endtask

    task automatic send_block(input logic [127:0] blk, input bit is_key);
        send_word(blk[127:96], is_key);
        send_word(blk[95:64],  is_key);
        send_word(blk[63:32],  is_key);
        send_word(blk[31:0],   is_key);
    endtask

    // mode 0: always ready, 1: 10 stalled cycles then toggle, 2: random ready
    task automatic drain(input int mode);
        int cyc = 0;
        int low = 0;
        bit stalled = 1'b0;
        logic [31:0] held = '0;
        while (exp_q.size() != 0 && cyc < 400) begin
            if (mode == 0) sif.out_ready = 1'b1;
            else if (mode == 1) begin
                if (low < 10) begin
                    sif.out_ready = 1'b0;
                    if (sif.out_valid) low++;
                end else sif.out_ready = ~sif.out_ready;
            end else sif.out_ready = 1'($urandom_range(0, 1));
            if (stalled) chk("out_hold", sif.out_data, held);
            if (sif.out_valid) chk("in_ready_drain", sif.in_ready, 0);
            stalled = sif.out_valid && !sif.out_ready;
            held    = sif.out_data;
            if (sif.out_valid && sif.out_ready) chk("out_word", sif.out_data, exp_q.pop_front());
            tick();
            cyc++;
        end
        sif.out_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
        chk("out_valid_drop", sif.out_valid, 0);
        chk("busy_idle", busy, 0);
        chk("in_ready_idle", sif.in_ready, 1);
    endtask

    initial begin
        logic [127:0] rk, rt;
        sif.in_data   = '0;
        sif.in_key    = 1'b0;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b0;
        err_clr       = 1'b0;
        extra_done    = 1'b0;
        stub_en       = 1'b1;
        done_lat      = 3;
        model_reset();

        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", sif.in_ready, 0);
        chk("rst_ld", aes_ld, 0);
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key", aes_key, 0);
        chk("rst_text", aes_text_in, 0);
        chk("rst_key_vld", dbg_key_vld, 0);
        chk("rst_state", dbg_state, COLLECT);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("idle_in_ready", sif.in_ready, 1);

        // Text before key: fifth text word is dropped, key completes the load.
        rt = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        send_block(rt, 1'b0);
        chk("no_err_yet", err, 0);
        send_word($urandom, 1'b0);
        chk("err_drop", err, 1);
        send_block(rk, 1'b1);
        done_lat = 4;
        drain(2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", err, 0);

        // FIPS-197 vector.
        send_block(FIPS_KEY, 1'b1);
        send_block(FIPS_PT, 1'b0);
        drain(0);
        chk("fips_err", err, 0);

        // Key reuse.
        send_block(128'hffeeddccbbaa99887766554433221100, 1'b0);
        drain(0);

        // aes_done outside WAIT.
        extra_done = 1'b1;
        tick();
        extra_done = 1'b0;
        chk("stray_done_busy", busy, 0);
        chk("stray_done_valid", sif.out_valid, 0);

        // Output backpressure.
        done_lat = 7;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drain(1);

        // Timeout with a silent core.
        stub_en = 1'b0;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        exp_q.delete();
        repeat (DONE_TIMEOUT) tick();
        chk("tmo_err_before", err, 0);
        chk("tmo_busy_before", busy, 1);
        tick();
        chk("tmo_err", err, 1);
        chk("tmo_state", dbg_state, COLLECT);
        chk("tmo_in_ready", sif.in_ready, 1);
        chk("tmo_key_kept", dbg_key_vld, 1);
        repeat (5) begin
            tick();
            chk("tmo_no_valid", sif.out_valid, 0);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_err_clr", err, 0);
        stub_en = 1'b1;

        // Reset during WAIT.
        done_lat = 25;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (3) tick();
        chk("wait_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_key", aes_key, 0);
        chk("mid_rst_text", aes_text_in, 0);
        chk("mid_rst_key_vld", dbg_key_vld, 0);
        chk("mid_rst_in_ready", sif.in_ready, 0);
        chk("mid_rst_ld", aes_ld, 0);
        chk("mid_rst_valid", sif.out_valid, 0);
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        tick();
        done_lat = 5;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drain(0);

        // Randomized blocks, optional rekey, random latency and backpressure.
        for (int b = 0; b < 8; b++) begin
            done_lat = $urandom_range(1, 25);
            if ($urandom_range(0, 1) == 1)
                send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1);
            send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
            drain(2);
        end
        chk("final_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
